arm_shifter_pipe: RTL and testbench

- Pipelined, handshaked ARM operand-2 barrel shifter for the datapath; replaces the purely combinational shifter.
- Full ARM semantics: immediate rotate, immediate-amount and register-amount LSL/LSR/ASR/ROR, RRX, shifter carry-out.
- Parametrised width and pipeline depth; valid/ready on both sides with backpressure and flush. Sits between register-file read and ALU input B; CarryOut feeds the flag logic.

---
 rtl/arm_shifter_pipe.sv | 195 +++++++++++++++++++
 tb/tb_arm_shifter_pipe.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_shifter_pipe.sv
// ARM operand-2 barrel shifter with a valid/ready pipeline of 1 or 2 stages.
// Decode maps every encoding onto a small operation set; the shifter then
// resolves out-of-range amounts and the shifter carry.
module arm_shifter_pipe #(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Flush,
   input  logic             InValid,
   output logic             InReady,
   input  logic [WIDTH-1:0] Number,
   input  logic [11:0]      Shift,
   input  logic [7:0]       ShiftReg,
   input  logic             I,
   input  logic             En,
   input  logic             CarryIn,
   output logic             OutValid,
   input  logic             OutReady,
   output logic [WIDTH-1:0] Out,
   output logic             CarryOut
);

   localparam int unsigned LW = $clog2(WIDTH);

   typedef enum logic [2:0] {
      OP_PASS, OP_LSL, OP_LSR, OP_ASR, OP_ROR, OP_RRX
   } op_e;

   typedef struct packed {
      op_e              op;
      logic [7:0]       amt;
      logic [WIDTH-1:0] num;
      logic             cin;
   } dec_t;

   dec_t             dec_c;
   dec_t             sh_src;
   logic             src_valid;
   logic             ready_last;
   logic             in_ready_c;
   logic             in_fire;
   logic [WIDTH-1:0] sh_out;
   logic             sh_c;
   logic [2*WIDTH-1:0] wide;
   logic [LW-1:0]    rot;

   function automatic op_e typ_op(input logic [1:0] t);
      case (t)
         2'b00:   return OP_LSL;
         2'b01:   return OP_LSR;
         2'b10:   return OP_ASR;
         default: return OP_ROR;
      endcase
   endfunction

   assign ready_last = !OutValid | OutReady;
   assign InReady    = !Flush & in_ready_c;
   assign in_fire    = InValid & InReady;

   // Decode the operand-2 field into operation, effective amount and source
   always_comb begin
      dec_c.op  = OP_PASS;
      dec_c.amt = '0;
      dec_c.num = Number;
      dec_c.cin = CarryIn;
      if (En) begin
         if (I) begin
            // Immediate: rotate imm8 by 2*rot; rot==0 leaves carry untouched
            dec_c.num = WIDTH'(Shift[7:0]);
            dec_c.amt = {3'b000, Shift[11:8], 1'b0};
            if (Shift[11:8] != 4'd0) dec_c.op = OP_ROR;
         end else if (Shift[4]) begin
            dec_c.amt = ShiftReg;
            if (ShiftReg != 8'd0) dec_c.op = typ_op(Shift[6:5]);
         end else begin
            dec_c.amt = {3'b000, Shift[11:7]};
            if (Shift[11:7] != 5'd0) begin
               dec_c.op = typ_op(Shift[6:5]);
            end else begin
               // Zero immediate amount: LSR/ASR mean full width, ROR means RRX
               case (Shift[6:5])
                  2'b01: begin dec_c.op = OP_LSR; dec_c.amt = 8'(WIDTH); end
                  2'b10: begin dec_c.op = OP_ASR; dec_c.amt = 8'(WIDTH); end
                  2'b11: dec_c.op = OP_RRX;
                  default: dec_c.op = OP_PASS;
               endcase
            end
         end
      end
   end

   // Barrel shift with ARM carry rules; double-width vectors expose the carry bit
   always_comb begin
      sh_out = sh_src.num;
      sh_c   = sh_src.cin;
      wide   = '0;
      rot    = sh_src.amt[LW-1:0];
      case (sh_src.op)
         OP_LSL: begin
            if (sh_src.amt > 8'(WIDTH)) begin
               sh_out = '0;
               sh_c   = 1'b0;
            end else begin
               wide   = {WIDTH'(0), sh_src.num} << sh_src.amt;
               sh_out = wide[WIDTH-1:0];
               sh_c   = wide[WIDTH];
            end
         end
         OP_LSR: begin
            if (sh_src.amt > 8'(WIDTH)) begin
               sh_out = '0;
               sh_c   = 1'b0;
            end else begin
               wide   = {sh_src.num, WIDTH'(0)} >> sh_src.amt;
               sh_out = wide[2*WIDTH-1:WIDTH];
               sh_c   = wide[WIDTH-1];
            end
         end
         OP_ASR: begin
            if (sh_src.amt >= 8'(WIDTH)) begin
               sh_out = {WIDTH{sh_src.num[WIDTH-1]}};
               sh_c   = sh_src.num[WIDTH-1];
            end else begin
               wide   = $unsigned($signed({sh_src.num, WIDTH'(0)}) >>> sh_src.amt);
               sh_out = wide[2*WIDTH-1:WIDTH];
               sh_c   = wide[WIDTH-1];
            end
         end
         OP_ROR: begin
            if (rot == '0) begin
               sh_out = sh_src.num;
               sh_c   = sh_src.num[WIDTH-1];
            end else begin
               wide   = {sh_src.num, sh_src.num} >> rot;
               sh_out = wide[WIDTH-1:0];
               sh_c   = wide[WIDTH-1];
            end
         end
         OP_RRX: begin
            sh_out = {sh_src.cin, sh_src.num[WIDTH-1:1]};
            sh_c   = sh_src.num[0];
         end
         default: begin
            sh_out = sh_src.num;
            sh_c   = sh_src.cin;
         end
      endcase
   end

   if (STAGES == 2) begin : g_two
      logic v1;
      dec_t d1;

      assign in_ready_c = !v1 | ready_last;
      assign sh_src     = d1;
      assign src_valid  = v1;

      // Decode register: advances when empty or when the output stage takes it
      always_ff @(posedge clk) begin
         if (reset) begin
            v1 <= 1'b0;
            d1 <= '0;
         end else if (Flush) begin
            v1 <= 1'b0;
         end else if (in_ready_c) begin
            v1 <= in_fire;
            if (in_fire) d1 <= dec_c;
         end
      end
   end else begin : g_one
      assign in_ready_c = ready_last;
      assign sh_src     = dec_c;
      assign src_valid  = in_fire;
   end

   // Output register: holds while stalled, loads only on a valid source
   always_ff @(posedge clk) begin
      if (reset) begin
         OutValid <= 1'b0;
         Out      <= '0;
         CarryOut <= 1'b0;
      end else if (Flush) begin
         OutValid <= 1'b0;
      end else if (ready_last) begin
         OutValid <= src_valid;
         if (src_valid) begin
            Out      <= sh_out;
            CarryOut <= sh_c;
         end
      end
   end

endmodule

// File: tb/tb_arm_shifter_pipe.sv
// Bench for arm_shifter_pipe: four configurations share one stimulus bus,
// each with its own expected-result queue.
module tb_arm_shifter_pipe;

   localparam int NDUT = 4;

   typedef struct packed {
      logic [63:0] d;
      logic        c;
   } res_t;

   typedef struct {
      logic        i, en, cin;
      logic [11:0] sh;
      logic [7:0]  sr;
      logic [63:0] n;
      logic [31:0] eo;
      logic        ec;
   } vec_t;

   logic        clk, reset, Flush, InValid, OutReady, I, En, CarryIn;
   logic [63:0] Number;
   logic [11:0] Shift;
   logic [7:0]  ShiftReg;

   logic        rdy0, rdy1, rdy2, rdy3, v0, v1, v2, v3, c0, c1, c2, c3;
   logic [31:0] o0, o1;
   logic [15:0] o2;
   logic [63:0] o3;

   logic        in_rdy [NDUT];
   logic        out_v  [NDUT];
   logic        out_c  [NDUT];
   logic [63:0] out_d  [NDUT];

   res_t sbq [NDUT][$];
   vec_t tab [15];
   int   checks, errors;
   logic tab_en;
   res_t tab_exp;

   arm_shifter_pipe #(.WIDTH(32), .STAGES(1)) u_w32s1 (
      .clk(clk), .reset(reset), .Flush(Flush), .InValid(InValid), .InReady(rdy0),
      .Number(Number[31:0]), .Shift(Shift), .ShiftReg(ShiftReg), .I(I), .En(En),
      .CarryIn(CarryIn), .OutValid(v0), .OutReady(OutReady), .Out(o0), .CarryOut(c0));
   arm_shifter_pipe #(.WIDTH(32), .STAGES(2)) u_w32s2 (
      .clk(clk), .reset(reset), .Flush(Flush), .InValid(InValid), .InReady(rdy1),
      .Number(Number[31:0]), .Shift(Shift), .ShiftReg(ShiftReg), .I(I), .En(En),
      .CarryIn(CarryIn), .OutValid(v1), .OutReady(OutReady), .Out(o1), .CarryOut(c1));
   arm_shifter_pipe #(.WIDTH(16), .STAGES(1)) u_w16s1 (
      .clk(clk), .reset(reset), .Flush(Flush), .InValid(InValid), .InReady(rdy2),
      .Number(Number[15:0]), .Shift(Shift), .ShiftReg(ShiftReg), .I(I), .En(En),
      .CarryIn(CarryIn), .OutValid(v2), .OutReady(OutReady), .Out(o2), .CarryOut(c2));
   arm_shifter_pipe #(.WIDTH(64), .STAGES(2)) u_w64s2 (
      .clk(clk), .reset(reset), .Flush(Flush), .InValid(InValid), .InReady(rdy3),
      .Number(Number), .Shift(Shift), .ShiftReg(ShiftReg), .I(I), .En(En),
      .CarryIn(CarryIn), .OutValid(v3), .OutReady(OutReady), .Out(o3), .CarryOut(c3));

   always_comb begin
      in_rdy[0] = rdy0; in_rdy[1] = rdy1; in_rdy[2] = rdy2; in_rdy[3] = rdy3;
      out_v[0]  = v0;   out_v[1]  = v1;   out_v[2]  = v2;   out_v[3]  = v3;
      out_c[0]  = c0;   out_c[1]  = c1;   out_c[2]  = c2;   out_c[3]  = c3;
      out_d[0]  = 64'(o0);
      out_d[1]  = 64'(o1);
      out_d[2]  = 64'(o2);
      out_d[3]  = o3;
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired actual=running required=finished");
      $fatal(1);
   end

   function automatic int dut_w(input int k);
      case (k)
         2:       return 16;
         3:       return 64;
         default: return 32;
      endcase
   endfunction

   // Bit-by-bit reference of the ARM shifter at a run-time width
   function automatic res_t model(input int w, input logic [63:0] n, input logic [11:0] sh,
                                  input logic [7:0] sr, input logic i, input logic en,
                                  input logic cin);
      res_t        r;
      int          a, rr;
      logic [1:0]  typ;
      logic [63:0] src, o;
      src = (w == 64) ? n : (n & ((64'd1 << w) - 64'd1));
      o   = '0;
      r.c = cin;
      if (!en) begin
         o = src;
      end else if (i) begin
         src = {56'd0, sh[7:0]};
         rr  = (2 * int'(sh[11:8])) % w;
         for (int j = 0; j < w; j++) o[j] = src[(j + rr) % w];
         r.c = (sh[11:8] == 4'd0) ? cin : o[w-1];
      end else begin
         typ = sh[6:5];
         a   = sh[4] ? int'(sr) : int'(sh[11:7]);
         if (a == 0 && (sh[4] || typ == 2'd0)) begin
            o = src;
         end else if (a == 0 && typ == 2'd3) begin
            o      = src >> 1;
            o[w-1] = cin;
            r.c    = src[0];
         end else begin
            if (a == 0) a = w;
            case (typ)
               2'd0: begin
                  for (int j = 0; j < w; j++) o[j] = (j >= a) ? src[j-a] : 1'b0;
                  r.c = (a <= w) ? src[w-a] : 1'b0;
               end
               2'd1: begin
                  for (int j = 0; j < w; j++) o[j] = (j + a < w) ? src[j+a] : 1'b0;
                  r.c = (a <= w) ? src[a-1] : 1'b0;
               end
               2'd2: begin
                  for (int j = 0; j < w; j++) o[j] = (j + a < w) ? src[j+a] : src[w-1];
                  r.c = (a <= w) ? src[a-1] : src[w-1];
               end
               default: begin
                  rr = a % w;
                  if (rr == 0) begin
                     o   = src;
                     r.c = src[w-1];
                  end else begin
                     for (int j = 0; j < w; j++) o[j] = src[(j + rr) % w];
                     r.c = o[w-1];
                  end
               end
            endcase
         end
      end
      r.d = o;
      return r;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Scoreboard step at the negative edge: pop on output transfer, push on input accept
   task automatic monitor();
      res_t e;
      for (int k = 0; k < NDUT; k++) begin
         if (reset || Flush) begin
            sbq[k].delete();
         end else begin
            if (out_v[k] && OutReady) begin
               if (sbq[k].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_out dut%0d actual=%0h required=none", k, out_d[k]);
               end else begin
                  e = sbq[k].pop_front();
                  chk($sformatf("out_dut%0d", k), out_d[k], e.d);
                  chk($sformatf("carry_dut%0d", k), 64'(out_c[k]), 64'(e.c));
               end
            end
            if (InValid && in_rdy[k]) begin
               if (tab_en && dut_w(k) == 32) e = tab_exp;
               else e = model(dut_w(k), Number, Shift, ShiftReg, I, En, CarryIn);
               sbq[k].push_back(e);
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic check_drained(input string nm);
      for (int k = 0; k < NDUT; k++)
         chk($sformatf("%s_left_dut%0d", nm, k), 64'(sbq[k].size()), 64'd0);
   endtask

   task automatic random_beat();
      Number   = {$urandom, $urandom};
      Shift    = 12'($urandom);
      ShiftReg = ($urandom % 2 == 0) ? 8'($urandom_range(0, 70)) : 8'($urandom);
      I        = ($urandom % 4 == 0);
      En       = ($urandom % 8 != 0);
      CarryIn  = 1'($urandom);
   endtask

   initial begin
      logic        rh [8];
      logic        vh [8];
      logic        sv [8];
      logic [63:0] oh [8];
      logic        acc;
      int          b, cyc;

      checks = 0; errors = 0; tab_en = 1'b0; tab_exp = '0;
      reset = 1'b1; Flush = 1'b0; InValid = 1'b0; OutReady = 1'b1;
      I = 1'b0; En = 1'b1; CarryIn = 1'b0; Number = '0; Shift = '0; ShiftReg = '0;

      tab[0]  = '{1'b1, 1'b1, 1'b0, 12'h1FF, 8'd0,   64'h0,        32'hC000003F, 1'b1};
      tab[1]  = '{1'b1, 1'b1, 1'b1, 12'h0FF, 8'd0,   64'h0,        32'h000000FF, 1'b1};
      tab[2]  = '{1'b0, 1'b1, 1'b0, 12'h010, 8'd32,  64'h1,        32'h00000000, 1'b1};
      tab[3]  = '{1'b0, 1'b1, 1'b0, 12'h010, 8'd33,  64'h1,        32'h00000000, 1'b0};
      tab[4]  = '{1'b0, 1'b1, 1'b1, 12'h010, 8'd0,   64'h1,        32'h00000001, 1'b1};
      tab[5]  = '{1'b0, 1'b1, 1'b0, 12'h040, 8'd0,   64'h80000000, 32'hFFFFFFFF, 1'b1};
      tab[6]  = '{1'b0, 1'b1, 1'b0, 12'h020, 8'd0,   64'h80000000, 32'h00000000, 1'b1};
      tab[7]  = '{1'b0, 1'b1, 1'b1, 12'h060, 8'd0,   64'h3,        32'h80000001, 1'b1};
      tab[8]  = '{1'b0, 1'b1, 1'b0, 12'h070, 8'h20,  64'h80000001, 32'h80000001, 1'b1};
      tab[9]  = '{1'b0, 1'b1, 1'b0, 12'h070, 8'h04,  64'h80000001, 32'h18000000, 1'b0};
      tab[10] = '{1'b0, 1'b0, 1'b1, 12'hFFF, 8'hFF,  64'h12345678, 32'h12345678, 1'b1};
      tab[11] = '{1'b0, 1'b1, 1'b0, 12'h200, 8'd0,   64'hF000000F, 32'h000000F0, 1'b1};
      tab[12] = '{1'b0, 1'b1, 1'b0, 12'h0B0, 8'd1,   64'h3,        32'h00000001, 1'b1};
      tab[13] = '{1'b0, 1'b1, 1'b0, 12'h010, 8'd64,  64'h1,        32'h00000000, 1'b0};
      tab[14] = '{1'b1, 1'b1, 1'b1, 12'h8AB, 8'd0,   64'h0,        32'h00AB0000, 1'b0};

      // Reset state
      @(posedge clk);
      #1;
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("rst_valid_dut%0d", k), 64'(out_v[k]), 64'd0);
         chk($sformatf("rst_out_dut%0d", k), out_d[k], 64'd0);
         chk($sformatf("rst_carry_dut%0d", k), 64'(out_c[k]), 64'd0);
      end
      tick();
      reset = 1'b0;
      tick();

      // Directed vectors, one beat per cycle, no backpressure
      for (int v = 0; v < 15; v++) begin
         I = tab[v].i; En = tab[v].en; CarryIn = tab[v].cin;
         Shift = tab[v].sh; ShiftReg = tab[v].sr; Number = tab[v].n;
         tab_en = 1'b1;
         tab_exp.d = 64'(tab[v].eo);
         tab_exp.c = tab[v].ec;
         InValid = 1'b1;
         tick();
      end
      InValid = 1'b0;
      tab_en  = 1'b0;
      repeat (5) tick();
      check_drained("table");

      // Back-to-back beats against a stalled consumer
      I = 1'b0; En = 1'b1; CarryIn = 1'b0; Shift = 12'h010;
      b = 0; cyc = 0;
      Number = 64'h1111111111111111; ShiftReg = 8'd1;
      for (int j = 0; j < 8; j++) begin
         rh[j] = 1'b0; vh[j] = 1'b0; sv[j] = 1'b0; oh[j] = '0;
      end
      InValid = 1'b1;
      while (b < 4 && cyc < 40) begin
         OutReady = (cyc >= 4);
         @(negedge clk);
         if (cyc < 8) begin
            rh[cyc] = in_rdy[1]; vh[cyc] = out_v[1]; oh[cyc] = out_d[1]; sv[cyc] = out_v[0];
         end
         acc = in_rdy[1];
         monitor();
         @(posedge clk);
         #1;
         cyc++;
         if (acc) begin
            b++;
            Number   = 64'(b + 1) * 64'h1111111111111111;
            ShiftReg = 8'(b + 1);
         end
      end
      InValid = 1'b0;
      chk("stall_beats_accepted", 64'(b), 64'd4);
      chk("stall_rdy_c0", 64'(rh[0]), 64'd1);
      chk("stall_rdy_c1", 64'(rh[1]), 64'd1);
      chk("stall_rdy_c2", 64'(rh[2]), 64'd0);
      chk("stall_rdy_c3", 64'(rh[3]), 64'd0);
      chk("stall_valid_c1_s2", 64'(vh[1]), 64'd0);
      chk("stall_valid_c2_s2", 64'(vh[2]), 64'd1);
      chk("stall_valid_c1_s1", 64'(sv[1]), 64'd1);
      chk("stall_valid_c3_s2", 64'(vh[3]), 64'd1);
      chk("stall_first_out", oh[2], 64'h22222222);
      chk("stall_hold_c3", oh[3], oh[2]);
      chk("stall_hold_c4", oh[4], 64'h22222222);
      OutReady = 1'b1;
      repeat (6) tick();
      check_drained("stall");

      // Flush with entries in flight
      OutReady = 1'b0;
      InValid  = 1'b1;
      repeat (2) begin
         random_beat();
         tick();
      end
      Flush = 1'b1;
      @(negedge clk);
      for (int k = 0; k < NDUT; k++)
         chk($sformatf("flush_inready_dut%0d", k), 64'(in_rdy[k]), 64'd0);
      monitor();
      @(posedge clk);
      #1;
      Flush   = 1'b0;
      InValid = 1'b0;
      @(negedge clk);
      for (int k = 0; k < NDUT; k++)
         chk($sformatf("flush_valid_dut%0d", k), 64'(out_v[k]), 64'd0);
      monitor();
      @(posedge clk);
      #1;
      OutReady = 1'b1;
      repeat (4) tick();
      check_drained("flush");

      // Reset in the middle of a stream
      InValid = 1'b1;
      repeat (3) begin
         random_beat();
         tick();
      end
      reset = 1'b1;
      tick();
      for (int k = 0; k < NDUT; k++) begin
         chk($sformatf("midrst_valid_dut%0d", k), 64'(out_v[k]), 64'd0);
         chk($sformatf("midrst_out_dut%0d", k), out_d[k], 64'd0);
         chk($sformatf("midrst_carry_dut%0d", k), 64'(out_c[k]), 64'd0);
      end
      reset   = 1'b0;
      InValid = 1'b0;
      repeat (4) tick();
      check_drained("midrst");

      // Random traffic with random backpressure
      for (int n = 0; n < 300; n++) begin
         random_beat();
         InValid  = ($urandom % 4 != 0);
         OutReady = ($urandom % 4 != 0);
         tick();
      end
      InValid  = 1'b0;
      OutReady = 1'b1;
      repeat (6) tick();
      check_drained("random");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
